// File: rtl/cpu_pkg.sv
// Shared core definitions: immediate-format codes, RV32I major opcodes and
// small helpers used by the encoder and the decode side of the core.
package cpu_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100,
    IMM_R = 3'b101
  } imm_src_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Instruction bits owned by the immediate in each format.
  localparam logic [31:0] MASK_I  = 32'hFFF0_0000;
  localparam logic [31:0] MASK_SB = 32'hFE00_0F80;
  localparam logic [31:0] MASK_JU = 32'hFFFF_F000;
  localparam logic [31:0] MASK_R  = 32'h0000_0000;

  // True when v[31:lsb] are all copies of one bit, i.e. v fits as a signed
  // value of lsb+1 bits.
  function automatic logic upper_bits_uniform(input logic [31:0] v,
                                              input logic [4:0]  lsb);
    logic [31:0] s;
    s = 32'($signed(v) >>> lsb);
    return (s == 32'h0000_0000) || (s == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Immediate scatter: places imm_i into its RV32I bit positions for the chosen
// format and reports whether the value is representable in that format.
module imm_pack
  import cpu_pkg::*;
(
  input  logic [31:0] imm_i,
  input  logic [2:0]  imm_src_i,
  output logic [31:0] imm_bits_o,
  output logic [31:0] imm_mask_o,
  output logic        range_ok_o
);

  // Per-format scatter, ownership mask and range check
  always_comb begin
    imm_bits_o = 32'h0000_0000;
    imm_mask_o = MASK_R;
    range_ok_o = 1'b0;
    case (imm_src_t'(imm_src_i))
      IMM_I: begin
        imm_bits_o = {imm_i[11:0], 20'h0_0000};
        imm_mask_o = MASK_I;
        range_ok_o = upper_bits_uniform(imm_i, 5'd11);
      end
      IMM_S: begin
        imm_bits_o = {imm_i[11:5], 13'h0000, imm_i[4:0], 7'h00};
        imm_mask_o = MASK_SB;
        range_ok_o = upper_bits_uniform(imm_i, 5'd11);
      end
      IMM_B: begin
        imm_bits_o = {imm_i[12], imm_i[10:5], 13'h0000, imm_i[4:1], imm_i[11], 7'h00};
        imm_mask_o = MASK_SB;
        range_ok_o = upper_bits_uniform(imm_i, 5'd12) && (imm_i[0] == 1'b0);
      end
      IMM_J: begin
        imm_bits_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], 12'h000};
        imm_mask_o = MASK_JU;
        range_ok_o = upper_bits_uniform(imm_i, 5'd20) && (imm_i[0] == 1'b0);
      end
      IMM_U: begin
        imm_bits_o = {imm_i[31:12], 12'h000};
        imm_mask_o = MASK_JU;
        range_ok_o = (imm_i[11:0] == 12'h000);
      end
      IMM_R: begin
        imm_bits_o = 32'h0000_0000;
        imm_mask_o = MASK_R;
        range_ok_o = 1'b1;
      end
      default: begin
        imm_bits_o = 32'h0000_0000;
        imm_mask_o = MASK_R;
        range_ok_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs fields and immediate into a word, streams it
// with a byte address over valid/ready, and counts rejected (out-of-range) inputs.
module instr_encoder
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [6:0]               opcode_i,
  input  logic [4:0]               rd_i,
  input  logic [4:0]               rs1_i,
  input  logic [4:0]               rs2_i,
  input  logic [2:0]               funct3_i,
  input  logic [6:0]               funct7_i,
  input  logic [31:0]              imm_i,
  input  logic [2:0]               imm_src_i,
  input  logic                     load_i,
  input  logic [ADDR_WIDTH-1:0]    base_addr_i,
  input  logic                     clr_err_i,
  output logic [31:0]              instr_o,
  output logic [ADDR_WIDTH-1:0]    addr_o,
  output logic                     instr_valid_o,
  input  logic                     instr_ready_i,
  output logic                     err_o,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
);

  localparam logic [ADDR_WIDTH-1:0]    ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0]    ADDR_STEP = ADDR_WIDTH'(32'd4);
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_ZERO  = {ERR_CNT_WIDTH{1'b0}};
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE   = ERR_CNT_WIDTH'(32'd1);
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX   = {ERR_CNT_WIDTH{1'b1}};

  logic [31:0]              imm_bits_s;
  logic [31:0]              imm_mask_s;
  logic                     range_ok_s;
  logic [31:0]              base_word_s;
  logic [31:0]              encoded_s;
  logic                     accept_s;
  logic                     take_word_s;
  logic                     reject_s;
  logic [ADDR_WIDTH-1:0]    base_aligned_s;
  logic [ADDR_WIDTH-1:0]    word_addr_s;
  logic                     base_lsb_unused_s;

  logic [31:0]              instr_q,    instr_d;
  logic [ADDR_WIDTH-1:0]    addr_q,     addr_d;
  logic                     valid_q,    valid_d;
  logic [ADDR_WIDTH-1:0]    addr_cnt_q, addr_cnt_d;
  logic                     err_q,      err_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q,  err_cnt_d;

  imm_pack u_imm_pack (
    .imm_i      (imm_i),
    .imm_src_i  (imm_src_i),
    .imm_bits_o (imm_bits_s),
    .imm_mask_o (imm_mask_s),
    .range_ok_o (range_ok_s)
  );

  // R-type keeps funct7 in [31:25]; every other format overlays its imm bits.
  assign base_word_s = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
  assign encoded_s   = (base_word_s & ~imm_mask_s) | (imm_bits_s & imm_mask_s);

  assign ready_o     = !valid_q || instr_ready_i;
  assign accept_s    = valid_i && ready_o;
  assign take_word_s = accept_s && range_ok_s;
  assign reject_s    = accept_s && !range_ok_s;

  assign base_aligned_s    = {base_addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign base_lsb_unused_s = ^base_addr_i[1:0];
  assign word_addr_s       = load_i ? base_aligned_s : addr_cnt_q;

  // Output word register: capture on a legal accept, drop on retirement
  always_comb begin
    instr_d = instr_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    if (take_word_s) begin
      instr_d = encoded_s;
      addr_d  = word_addr_s;
      valid_d = 1'b1;
    end else if (instr_ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Address counter: load wins, then advance only past a produced word
  always_comb begin
    addr_cnt_d = word_addr_s + (take_word_s ? ADDR_STEP : ADDR_ZERO);
  end

  // Sticky error flag and saturating reject counter; a reject beats a clear
  always_comb begin
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (clr_err_i) begin
      err_d     = reject_s;
      err_cnt_d = reject_s ? CNT_ONE : CNT_ZERO;
    end else if (reject_s) begin
      err_d     = 1'b1;
      err_cnt_d = (err_cnt_q == CNT_MAX) ? err_cnt_q : err_cnt_q + CNT_ONE;
    end else begin
      err_d     = err_q;
      err_cnt_d = err_cnt_q;
    end
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_q    <= 32'h0000_0000;
      addr_q     <= ADDR_ZERO;
      valid_q    <= 1'b0;
      addr_cnt_q <= ADDR_ZERO;
      err_q      <= 1'b0;
      err_cnt_q  <= CNT_ZERO;
    end else begin
      instr_q    <= instr_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      addr_cnt_q <= addr_cnt_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign instr_o       = instr_q;
  assign addr_o        = addr_q;
  assign instr_valid_o = valid_q;
  assign err_o         = err_q;
  assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed and randomized fields checked
// against an arithmetic reference model and an independent immediate decoder.
module tb_instr_encoder;
  import cpu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i, ready_o;
  logic [6:0]  opcode_i, funct7_i;
  logic [4:0]  rd_i, rs1_i, rs2_i;
  logic [2:0]  funct3_i, imm_src_i;
  logic [31:0] imm_i, base_addr_i, instr_o, addr_o;
  logic        load_i, clr_err_i, instr_valid_o, instr_ready_i, err_o;
  logic [7:0]  err_cnt_o;

  logic        v8, ready8, load8, ivalid8, err8;
  logic [7:0]  base8, addr8, errcnt8;
  logic [31:0] instr8;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_addr;
  logic [31:0] retired_q[$];
  logic [31:0] j_words[3];
  bit          collect = 1'b0;

  always #5 clk_i = ~clk_i;

  instr_encoder #(.ADDR_WIDTH(32), .ERR_CNT_WIDTH(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .opcode_i(opcode_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .funct3_i(funct3_i), .funct7_i(funct7_i), .imm_i(imm_i), .imm_src_i(imm_src_i),
    .load_i(load_i), .base_addr_i(base_addr_i), .clr_err_i(clr_err_i),
    .instr_o(instr_o), .addr_o(addr_o), .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i), .err_o(err_o), .err_cnt_o(err_cnt_o)
  );

  instr_encoder #(.ADDR_WIDTH(8), .ERR_CNT_WIDTH(8)) dut8 (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(v8), .ready_o(ready8),
    .opcode_i(opcode_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .funct3_i(funct3_i), .funct7_i(funct7_i), .imm_i(imm_i), .imm_src_i(imm_src_i),
    .load_i(load8), .base_addr_i(base8), .clr_err_i(1'b0),
    .instr_o(instr8), .addr_o(addr8), .instr_valid_o(ivalid8),
    .instr_ready_i(1'b1), .err_o(err8), .err_cnt_o(errcnt8)
  );

  always @(posedge clk_i)
    if (collect && instr_valid_o && instr_ready_i) retired_q.push_back(instr_o);

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic bit ref_legal(input int src, input logic [31:0] imm);
    longint v;
    v = longint'($signed(imm));
    case (src)
      0, 1:    return (v >= -2048) && (v <= 2047);
      2:       return (v >= -4096) && (v <= 4094) && (imm[0] == 1'b0);
      3:       return (v >= -1048576) && (v <= 1048574) && (imm[0] == 1'b0);
      4:       return imm[11:0] == 12'h000;
      5:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_encode(input int src, input logic [31:0] imm,
      input logic [6:0] opc, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7);
    case (src)
      0:       return {imm[11:0], rs1, f3, rd, opc};
      1:       return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
      2:       return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
      3:       return {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
      4:       return {imm[31:12], rd, opc};
      default: return {f7, rs2, rs1, f3, rd, opc};
    endcase
  endfunction

  // Independent sign_extend model used for the round-trip check.
  function automatic logic [31:0] ref_decode(input int src, input logic [31:0] w);
    case (src)
      0:       return {{20{w[31]}}, w[31:20]};
      1:       return {{20{w[31]}}, w[31:25], w[11:7]};
      2:       return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3:       return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      4:       return {w[31:12], 12'h000};
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] rand_legal(input int src);
    int r;
    case (src)
      0, 1:    r = int'($urandom_range(4095, 0)) - 2048;
      2:       r = (int'($urandom_range(4095, 0)) - 2048) * 2;
      3:       r = (int'($urandom_range(1048575, 0)) - 524288) * 2;
      4:       r = int'($urandom & 32'hFFFF_F000);
      default: r = int'($urandom);
    endcase
    return 32'(r);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input int src, input logic [31:0] imm, input logic [6:0] opc,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [2:0] f3, input logic [6:0] f7);
    imm_src_i = 3'(src); imm_i = imm; opcode_i = opc; rd_i = rd;
    rs1_i = rs1; rs2_i = rs2; funct3_i = f3; funct7_i = f7;
    valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0; load_i = 1'b0; clr_err_i = 1'b0;
  endtask

  task automatic send_check(input string tag, input int src, input logic [31:0] imm,
      input logic [6:0] opc, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7);
    send(src, imm, opc, rd, rs1, rs2, f3, f7);
    if (ref_legal(src, imm)) begin
      check({tag, "_valid"}, {31'd0, instr_valid_o}, 32'd1);
      check({tag, "_instr"}, instr_o, ref_encode(src, imm, opc, rd, rs1, rs2, f3, f7));
      check({tag, "_addr"}, addr_o, exp_addr);
      if (src != 5) check({tag, "_rt"}, ref_decode(src, instr_o), imm);
      exp_addr += 32'd4;
    end else begin
      check({tag, "_valid"}, {31'd0, instr_valid_o}, 32'd0);
    end
  endtask

  initial begin
    int          bsrc[6];
    logic [31:0] bimm[6];
    int          src;
    logic [31:0] imm;

    rst_ni = 1'b0; valid_i = 1'b0; load_i = 1'b0; clr_err_i = 1'b0;
    instr_ready_i = 1'b1; base_addr_i = 32'h0; imm_i = 32'h0; imm_src_i = 3'd0;
    opcode_i = 7'h0; rd_i = 5'd0; rs1_i = 5'd0; rs2_i = 5'd0; funct3_i = 3'd0; funct7_i = 7'h0;
    v8 = 1'b0; load8 = 1'b0; base8 = 8'h00;
    #12;
    check("rst_instr", instr_o, 32'h0);
    check("rst_addr", addr_o, 32'h0);
    check("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    check("rst_cnt", {24'd0, err_cnt_o}, 32'd0);
    check("rst_ready", {31'd0, ready_o}, 32'd1);
    @(negedge clk_i); rst_ni = 1'b1;

    load_i = 1'b1; base_addr_i = 32'h0000_0103; exp_addr = 32'h0000_0100;
    send_check("addi", 0, 32'hFFFF_FFFF, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0);
    check("addi_const", instr_o, 32'hFFF0_0093);
    check("addi_addr_const", addr_o, 32'h0000_0100);
    send_check("beq", 2, 32'hFFFF_FFF8, OPC_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0);
    check("beq_const", instr_o, 32'hFE20_8CE3);
    check("beq_sext", ref_decode(2, instr_o), 32'hFFFF_FFF8);

    bsrc = '{0, 0, 2, 2, 3, 3};
    bimm = '{32'd2047, 32'hFFFF_F800, 32'd4094, 32'hFFFF_F000, 32'd1048574, 32'hFFF0_0000};
    for (int i = 0; i < 6; i++)
      send_check($sformatf("bound%0d", i), bsrc[i], bimm[i], OPC_JAL,
                 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom));

    for (int i = 0; i < 36; i++) begin
      src = i % 6;
      imm = rand_legal(src);
      send_check($sformatf("rand%0d", i), src, imm, 7'($urandom), 5'($urandom),
                 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom));
    end

    check("pre_err", {31'd0, err_o}, 32'd0);
    send_check("bad_i", 0, 32'd2048, OPC_OP_IMM, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0);
    send_check("bad_b", 2, 32'd3, OPC_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0);
    send_check("bad_u", 4, 32'h1234_5001, OPC_LUI, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0);
    send_check("bad_src", 7, 32'h0, OPC_OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0);
    check("bad_err", {31'd0, err_o}, 32'd1);
    check("bad_cnt", {24'd0, err_cnt_o}, 32'd4);
    clr_err_i = 1'b1; @(posedge clk_i); #1; clr_err_i = 1'b0;
    check("clr_err", {31'd0, err_o}, 32'd0);
    check("clr_cnt", {24'd0, err_cnt_o}, 32'd0);
    clr_err_i = 1'b1;
    send_check("clr_rej", 6, 32'h0, OPC_OP, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0);
    check("clr_rej_err", {31'd0, err_o}, 32'd1);
    check("clr_rej_cnt", {24'd0, err_cnt_o}, 32'd1);
    send_check("after_bad", 1, 32'hFFFF_FFF0, OPC_STORE, 5'd0, 5'd4, 5'd5, 3'd2, 7'd0);

    for (int i = 0; i < 260; i++) send(7, 32'h0, OPC_OP, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0);
    check("sat_cnt", {24'd0, err_cnt_o}, 32'd255);
    clr_err_i = 1'b1; @(posedge clk_i); #1; clr_err_i = 1'b0;
    check("sat_clr", {24'd0, err_cnt_o}, 32'd0);

    for (int i = 0; i < 3; i++)
      j_words[i] = ref_encode(3, 32'(i * 8 + 16), OPC_JAL, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0);
    retired_q.delete();
    collect = 1'b1; instr_ready_i = 1'b0;
    load_i = 1'b1; base_addr_i = 32'h0000_2000;
    send(3, 32'd16, OPC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0);
    check("bp_w0", instr_o, j_words[0]);
    check("bp_a0", addr_o, 32'h0000_2000);
    imm_i = 32'd24; rd_i = 5'd2; valid_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk_i); #1;
      check($sformatf("bp_hold%0d", c), instr_o, j_words[0]);
      check($sformatf("bp_ready%0d", c), {31'd0, ready_o}, 32'd0);
      check($sformatf("bp_haddr%0d", c), addr_o, 32'h0000_2000);
    end
    instr_ready_i = 1'b1; #1;
    check("bp_ready_up", {31'd0, ready_o}, 32'd1);
    @(posedge clk_i); #1;
    check("bp_w1", instr_o, j_words[1]);
    check("bp_a1", addr_o, 32'h0000_2004);
    imm_i = 32'd32; rd_i = 5'd3;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    check("bp_w2", instr_o, j_words[2]);
    check("bp_a2", addr_o, 32'h0000_2008);
    @(posedge clk_i); #1;
    collect = 1'b0;
    check("bp_count", 32'(retired_q.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < retired_q.size()) check($sformatf("bp_ret%0d", i), retired_q[i], j_words[i]);

    opcode_i = OPC_OP_IMM; imm_src_i = 3'd0; imm_i = 32'd5;
    load8 = 1'b1; base8 = 8'hFF; v8 = 1'b1;
    @(posedge clk_i); #1;
    load8 = 1'b0;
    check("wrap_a0", {24'd0, addr8}, 32'h0000_00FC);
    check("wrap_v0", {31'd0, ivalid8}, 32'd1);
    @(posedge clk_i); #1;
    v8 = 1'b0;
    check("wrap_a1", {24'd0, addr8}, 32'h0000_0000);

    send(0, 32'd4096, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0);
    instr_ready_i = 1'b0;
    send(4, 32'hABCD_E000, OPC_LUI, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0);
    check("mid_stall", {31'd0, instr_valid_o}, 32'd1);
    check("mid_cnt_pre", {24'd0, err_cnt_o}, 32'd1);
    rst_ni = 1'b0; #1;
    check("mid_valid", {31'd0, instr_valid_o}, 32'd0);
    check("mid_addr", addr_o, 32'h0);
    check("mid_instr", instr_o, 32'h0);
    check("mid_err", {31'd0, err_o}, 32'd0);
    check("mid_cnt", {24'd0, err_cnt_o}, 32'd0);
    @(negedge clk_i); rst_ni = 1'b1; instr_ready_i = 1'b1;
    exp_addr = 32'h0;
    send_check("post_rst", 4, 32'h0001_2000, OPC_AUIPC, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
